pwm_duty_ramp_ctrl: RTL
=======================

PWM_DUTY_RAMP_CTRL -- requirements
Module: pwm_duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_W, default 8, duty-cycle width.
REQ-002 SHALL have parameter DIV_W, default 8, step-period divider width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rises on clk.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port tgt_valid, input, 1, new target duty offered.
REQ-006 SHALL have port tgt_duty, input, DUTY_W, requested final duty.
REQ-007 SHALL have port tgt_ready, output, 1, target acceptance.
REQ-008 SHALL have port rate_div, input, DIV_W, clocks per step minus one.
REQ-009 SHALL have port step_size, input, 4, duty increment per step.
REQ-010 SHALL have port duty_out, output, DUTY_W, duty driven to the PWM peripheral.
REQ-011 SHALL have port busy, output, 1, high in RAMP_UP or RAMP_DOWN.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a ramp completes.

Function
REQ-013 SHALL implement states IDLE, RAMP_UP and RAMP_DOWN.
REQ-014 SHALL accept a target on any clock edge where tgt_valid and tgt_ready are both high.
REQ-015 SHALL capture tgt_duty, rate_div and step_size on acceptance, so later input changes do not affect the ramp in progress.
REQ-016 SHALL treat a captured step_size of 0 as 1.
REQ-017 SHALL, on acceptance in IDLE, compare the target with duty_out in the next cycle:
- target greater -> RAMP_UP
- target smaller -> RAMP_DOWN
- target equal -> stay IDLE and pulse done one cycle after acceptance.
REQ-018 SHALL load the step prescaler with rate_div on ramp entry, count it down by one per cycle, and generate a step tick when it reaches 0, then reload it.
REQ-019 SHALL space steps by rate_div+1 cycles; rate_div=0 gives one step per cycle.
REQ-020 SHALL, on each tick in RAMP_UP, set duty_out to min(duty_out+step, target), computed at DUTY_W+1 bits with no wrap.
REQ-021 SHALL, on each tick in RAMP_DOWN, set duty_out to max(duty_out-step, target), with no underflow.
REQ-022 SHALL, in the cycle duty_out becomes equal to target, return to IDLE with done high for exactly that next cycle.
REQ-023 SHALL change duty_out only on step ticks, and hold it in IDLE.
REQ-024 SHALL drive tgt_ready high in IDLE.

Reset
REQ-025 SHALL, when rst_n is low at a clk edge, set state=IDLE, duty_out=0, prescaler=0, captured target=0, busy=0 and done=0.
REQ-026 SHALL, on reset mid-ramp, abandon the ramp immediately with no done pulse.
REQ-027 SHALL drive tgt_ready=0 while rst_n is low.

Configuration
REQ-028 SHALL use macro PWM_RAMP_RETARGET_EN.
REQ-029 SHALL, without PWM_RAMP_RETARGET_EN, drive tgt_ready=0 in RAMP_UP and RAMP_DOWN.
REQ-030 SHALL, with PWM_RAMP_RETARGET_EN, drive tgt_ready=1 in all non-reset states; a mid-ramp acceptance SHALL:
- hold duty_out
- re-evaluate direction per REQ-017
- reload the prescaler
- issue no done pulse for the abandoned ramp.
REQ-031 SHALL, with PWM_RAMP_RETARGET_EN, give an acceptance priority over a step tick that falls in the same cycle, so the tick is discarded.

Structure
REQ-032 SHALL place the state enum (IDLE/RAMP_UP/RAMP_DOWN) and default DUTY_W/DIV_W constants in shared package pwm_ramp_pkg.
REQ-033 SHALL implement the prescaler as sub-module ramp_tick_gen, with inputs clk, rst_n, load and load_val[DIV_W] and output tick.

Verification
REQ-034 SHALL cover the up-ramp: reset, tgt_duty=0x10, rate_div=3, step=4 -> duty_out goes 0x04,0x08,0x0C,0x10 at 4-cycle intervals; done pulses once; busy falls with the IDLE return.
REQ-035 SHALL cover saturation: duty_out=0x10, tgt_duty=0x03, rate_div=0, step=5 -> duty_out goes 0x0B,0x06,0x03 on consecutive cycles with no underflow; done pulses once.
REQ-036 SHALL cover an equal target: duty_out=0x20, tgt_duty=0x20 -> no busy; done pulses one cycle after acceptance.
REQ-037 SHALL cover wrap protection: duty_out=0xFC, tgt_duty=0xFF, step=15 -> duty_out=0xFF in one step, never 0x0B.
REQ-038 SHALL cover reset mid-ramp: rst_n low during RAMP_UP at duty 0x08 -> the next cycle has duty_out=0, IDLE and no done.
REQ-039 SHALL cover the retarget contrast: during RAMP_UP toward 0x80, offer 0x00 -> without the macro tgt_ready=0 and the ramp completes to 0x80; with the macro the offer is accepted, the state becomes RAMP_DOWN, and only the final ramp pulses done.

Source files
------------

// File: rtl/pwm_ramp_pkg.sv
// Shared types and default widths for the PWM duty ramp controller.
// Used by pwm_duty_ramp_ctrl and ramp_tick_gen; retargeting is enabled with PWM_RAMP_RETARGET_EN.
package pwm_ramp_pkg;

   localparam int DUTY_W_DEF = 8;
   localparam int DIV_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_state_e;

   // A step of zero would stall a ramp forever, so it is promoted to one.
   function automatic logic [3:0] eff_step(input logic [3:0] s);
      return (s == 4'd0) ? 4'd1 : s;
   endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Step prescaler: reloads on load or after reaching zero, and ticks while the count is zero.
// Ticks are spaced load_val+1 cycles apart after each load.
module ramp_tick_gen
   import pwm_ramp_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load || (cnt == '0)) begin
         cnt <= load_val;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps duty_out toward an accepted target in step_size increments every rate_div+1 cycles.
// Optional macro PWM_RAMP_RETARGET_EN lets a new target be accepted mid-ramp.
module pwm_duty_ramp_ctrl
   import pwm_ramp_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tgt_valid,
   input  logic [DUTY_W-1:0] tgt_duty,
   output logic              tgt_ready,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic [3:0]        step_size,
   output logic [DUTY_W-1:0] duty_out,
   output logic              busy,
   output logic              done,
   output ramp_state_e       state_dbg
);

   // Handshake: a target transfers on a rising clk edge where tgt_valid && tgt_ready;
   // tgt_ready never depends on tgt_valid and is forced low while rst_n is low.

   ramp_state_e       state;
   logic [DUTY_W-1:0] tgt_q;
   logic [DIV_W-1:0]  rate_q;
   logic [3:0]        step_q;
   logic              ready_state;
   logic              accept;
   logic              tick;
   logic [DIV_W-1:0]  tick_load_val;
   logic [DUTY_W:0]   step_ext;
   logic [DUTY_W:0]   sum_up;
   logic [DUTY_W:0]   dn_lim;
   logic              up_hit;
   logic              dn_hit;
   logic [DUTY_W-1:0] dn_val;

`ifdef PWM_RAMP_RETARGET_EN
   assign ready_state = 1'b1;
`else
   assign ready_state = (state == IDLE);
`endif

   assign tgt_ready = rst_n && ready_state;
   assign accept    = tgt_valid && tgt_ready;
   assign state_dbg = state;

   // The prescaler must start from the incoming divider on the acceptance edge itself.
   assign tick_load_val = accept ? rate_div : rate_q;

   ramp_tick_gen #(
      .DIV_W(DIV_W)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .load_val(tick_load_val),
      .tick    (tick)
   );

   // Both directions are evaluated one bit wider so neither can wrap past the target.
   assign step_ext = {{(DUTY_W-3){1'b0}}, step_q};
   assign sum_up   = {1'b0, duty_out} + step_ext;
   assign dn_lim   = {1'b0, tgt_q} + step_ext;
   assign up_hit   = (sum_up >= {1'b0, tgt_q});
   assign dn_hit   = ({1'b0, duty_out} <= dn_lim);
   assign dn_val   = duty_out - step_ext[DUTY_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         duty_out <= '0;
         tgt_q    <= '0;
         rate_q   <= '0;
         step_q   <= 4'd1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            // Acceptance wins over a same-cycle tick: duty_out holds and the ramp restarts.
            tgt_q  <= tgt_duty;
            rate_q <= rate_div;
            step_q <= eff_step(step_size);
            if (tgt_duty > duty_out) begin
               state <= RAMP_UP;
               busy  <= 1'b1;
            end else if (tgt_duty < duty_out) begin
               state <= RAMP_DOWN;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end else if (tick) begin
            case (state)
               RAMP_UP: begin
                  if (up_hit) begin
                     duty_out <= tgt_q;
                     state    <= IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     duty_out <= sum_up[DUTY_W-1:0];
                  end
               end
               RAMP_DOWN: begin
                  if (dn_hit) begin
                     duty_out <= tgt_q;
                     state    <= IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     duty_out <= dn_val;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
